// File: rtl/cyber_player_multi_if.sv
// Press-generator bus: game-running qualifier and per-player difficulty in,
// per-player press pulses and press counters out.
interface cyber_player_multi_if #(
  parameter int N_PLAYERS = 2,
  parameter int DIFF_W    = 9,
  parameter int CNT_W     = 8
);
  logic                          enable;
  logic [N_PLAYERS*DIFF_W-1:0]   difficulty;
  logic [N_PLAYERS-1:0]          press;
  logic [N_PLAYERS*CNT_W-1:0]    press_cnt;

  modport master (output enable, output difficulty, input press, input press_cnt);
  modport slave  (input enable, input difficulty, output press, output press_cnt);
endinterface

// File: rtl/cyber_player_multi.sv
// N independent computer opponents for the tug-of-war game: each player has an
// LFSR, an IDLE/FIRE/COOL press FSM and a saturating press counter.
module cyber_player_multi #(
  parameter int                N_PLAYERS = 2,
  parameter int                LFSR_W    = 10,
  parameter logic [LFSR_W-1:0] TAPS      = 10'b1001000000,
  parameter logic [LFSR_W-1:0] SEED      = 10'h2A5,
  parameter int                DIFF_W    = 9,
  parameter int                COOLDOWN  = 4,
  parameter int                CNT_W     = 8
) (
  input logic                  clk,
  input logic                  reset,
  cyber_player_multi_if.slave  bus
);

  // Counter is at least one bit wide so a COOLDOWN of 0 still elaborates.
  localparam int               CD_W    = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(COOLDOWN);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FIRE = 2'd1,
    COOL = 2'd2
  } state_e;

  state_e               state_q [N_PLAYERS];
  state_e               state_d [N_PLAYERS];
  logic [LFSR_W-1:0]    lfsr_q  [N_PLAYERS];
  logic [LFSR_W-1:0]    lfsr_d  [N_PLAYERS];
  logic [CD_W-1:0]      cd_q    [N_PLAYERS];
  logic [CD_W-1:0]      cd_d    [N_PLAYERS];
  logic [CNT_W-1:0]     cnt_q   [N_PLAYERS];
  logic [CNT_W-1:0]     cnt_d   [N_PLAYERS];
  logic [N_PLAYERS-1:0] press_q;
  logic [N_PLAYERS-1:0] press_d;
  logic [N_PLAYERS-1:0] hit_s;

  function automatic logic [LFSR_W-1:0] seed_of(input int idx);
    logic [LFSR_W-1:0] s;
    s = SEED ^ LFSR_W'(idx + 1);
    if (s == {LFSR_W{1'b0}}) begin
      s = {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      s = s;
    end
    return s;
  endfunction

  // An all-zero register would stick forever, so it is forced back to 1.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
    logic [LFSR_W-1:0] n;
    if (cur == {LFSR_W{1'b0}}) begin
      n = {{(LFSR_W-1){1'b0}}, 1'b1};
    end else begin
      n = {cur[LFSR_W-2:0], ^(cur & TAPS)};
    end
    return n;
  endfunction

  // Per-player next state; press_d is the registered decode of entering FIRE
  // so press is high exactly while the player sits in FIRE.
  always_comb begin
    hit_s   = '0;
    press_d = '0;
    for (int i = 0; i < N_PLAYERS; i++) begin
      state_d[i] = state_q[i];
      cd_d[i]    = cd_q[i];
      cnt_d[i]   = cnt_q[i];
      lfsr_d[i]  = lfsr_next(lfsr_q[i]);
      hit_s[i]   = bus.enable && (state_q[i] == IDLE) &&
                   (lfsr_q[i][DIFF_W-1:0] < bus.difficulty[i*DIFF_W +: DIFF_W]);
      case (state_q[i])
        IDLE: begin
          if (hit_s[i]) begin
            state_d[i] = FIRE;
          end else begin
            state_d[i] = IDLE;
          end
        end
        FIRE: begin
          if (COOLDOWN == 0) begin
            state_d[i] = IDLE;
          end else begin
            state_d[i] = COOL;
            cd_d[i]    = CD_LOAD;
          end
        end
        COOL: begin
          cd_d[i] = cd_q[i] - CD_W'(1);
          if (cd_q[i] == CD_W'(1)) begin
            state_d[i] = IDLE;
          end else begin
            state_d[i] = COOL;
          end
        end
        default: begin
          state_d[i] = IDLE;
          cd_d[i]    = {CD_W{1'b0}};
        end
      endcase
      press_d[i] = (state_d[i] == FIRE);
      if (press_d[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end else begin
        cnt_d[i] = cnt_q[i];
      end
    end
  end

  // State, LFSR, cooldown and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      press_q <= '0;
      for (int i = 0; i < N_PLAYERS; i++) begin
        state_q[i] <= IDLE;
        lfsr_q[i]  <= seed_of(i);
        cd_q[i]    <= {CD_W{1'b0}};
        cnt_q[i]   <= {CNT_W{1'b0}};
      end
    end else begin
      press_q <= press_d;
      for (int i = 0; i < N_PLAYERS; i++) begin
        state_q[i] <= state_d[i];
        lfsr_q[i]  <= lfsr_d[i];
        cd_q[i]    <= cd_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  assign bus.press = press_q;

  for (genvar g = 0; g < N_PLAYERS; g++) begin : g_cnt
    assign bus.press_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_cyber_player_multi.sv
// Directed bench for cyber_player_multi: phase table plus corner-case sequences,
// with a cycle model of the opponents and pulse-spacing trackers.
module tb_cyber_player_multi;

  logic clk = 1'b0;
  logic reset;

  cyber_player_multi_if #(.N_PLAYERS(2), .DIFF_W(9), .CNT_W(8)) bus_a ();
  cyber_player_multi_if #(.N_PLAYERS(2), .DIFF_W(9), .CNT_W(4)) bus_b ();

  cyber_player_multi #(.N_PLAYERS(2), .COOLDOWN(4), .CNT_W(8)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  cyber_player_multi #(.N_PLAYERS(2), .COOLDOWN(0), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cycles;
    logic       rst;
    logic       en;
    logic [8:0] d0;
    logic [8:0] d1;
    logic [1:0] quiet;
    logic [1:0] active;
    int         exp_cnt0;
    int         exp_cnt1;
  } vec_t;

  vec_t tbl [6];

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model and tracker index k: 0,1 = dut_a players, 2,3 = dut_b players.
  int m_lfsr [4];
  int m_st   [4];
  int m_cd   [4];
  int m_cnt  [4];
  int prev_pr   [4] = '{0, 0, 0, 0};
  int last_rise [4] = '{-1, -1, -1, -1};
  int pulses    [4] = '{0, 0, 0, 0};
  int run_len   [4] = '{0, 0, 0, 0};

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int min_v);
    n_vec++;
    if (act < min_v) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0d expected>=%0d", name, cyc, act, min_v);
    end
  endtask

  function automatic int seed_of(input int p);
    int s;
    s = 'h2A5 ^ (p + 1);
    if (s == 0) s = 1;
    return s;
  endfunction

  function automatic int parity(input int v);
    int r;
    r = 0;
    for (int b = 0; b < 10; b++) r = r ^ ((v >> b) & 1);
    return r;
  endfunction

  function automatic int act_press(input int k);
    case (k)
      0: return int'(bus_a.press[0]);
      1: return int'(bus_a.press[1]);
      2: return int'(bus_b.press[0]);
      default: return int'(bus_b.press[1]);
    endcase
  endfunction

  function automatic int act_cnt(input int k);
    case (k)
      0: return int'(bus_a.press_cnt[7:0]);
      1: return int'(bus_a.press_cnt[15:8]);
      2: return int'(bus_b.press_cnt[3:0]);
      default: return int'(bus_b.press_cnt[7:4]);
    endcase
  endfunction

  function automatic int act_lfsr(input int k);
    case (k)
      0: return int'(dut_a.lfsr_q[0]);
      1: return int'(dut_a.lfsr_q[1]);
      2: return int'(dut_b.lfsr_q[0]);
      default: return int'(dut_b.lfsr_q[1]);
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      int p, cdv, cmax, en, dif, draw;
      bit hit;
      p    = k % 2;
      cdv  = (k < 2) ? 4 : 0;
      cmax = (k < 2) ? 255 : 15;
      if (k < 2) begin
        en  = int'(bus_a.enable);
        dif = int'(bus_a.difficulty[p*9 +: 9]);
      end else begin
        en  = int'(bus_b.enable);
        dif = int'(bus_b.difficulty[p*9 +: 9]);
      end
      if (reset) begin
        m_lfsr[k] = seed_of(p);
        m_st[k] = 0; m_cd[k] = 0; m_cnt[k] = 0;
        prev_pr[k] = 0; last_rise[k] = -1; pulses[k] = 0; run_len[k] = 0;
      end else begin
        draw = m_lfsr[k] & 'h1FF;
        hit  = (en != 0) && (m_st[k] == 0) && (draw < dif);
        if (m_lfsr[k] == 0) m_lfsr[k] = 1;
        else m_lfsr[k] = ((m_lfsr[k] << 1) & 'h3FF) | parity(m_lfsr[k] & 'h240);
        case (m_st[k])
          0: if (hit) m_st[k] = 1;
          1: begin
            if (cdv == 0) m_st[k] = 0;
            else begin m_st[k] = 2; m_cd[k] = cdv; end
          end
          default: begin
            if (m_cd[k] == 1) m_st[k] = 0;
            m_cd[k] = m_cd[k] - 1;
          end
        endcase
        if (m_st[k] == 1 && m_cnt[k] < cmax) m_cnt[k]++;
      end
    end
    cyc++;
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      int pr;
      pr = act_press(k);
      chk("press_model", pr, (m_st[k] == 1) ? 1 : 0);
      chk("cnt_model", act_cnt(k), m_cnt[k]);
      chk("lfsr_model", act_lfsr(k), m_lfsr[k]);
      if (pr != 0 && prev_pr[k] == 0) begin
        if (last_rise[k] >= 0) chk_ge("press_gap", cyc - last_rise[k], (k < 2) ? 6 : 2);
        last_rise[k] = cyc;
        pulses[k]++;
      end
      if (pr != 0) run_len[k]++;
      else begin
        if (prev_pr[k] != 0) chk("pulse_len", run_len[k], 1);
        run_len[k] = 0;
      end
      prev_pr[k] = pr;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int found, saved;
    tbl[0] = '{3,   1'b1, 1'b0, 9'h1FF, 9'h1FF, 2'b11, 2'b00, 0, 0};
    tbl[1] = '{50,  1'b0, 1'b0, 9'h1FF, 9'h1FF, 2'b11, 2'b00, 0, 0};
    tbl[2] = '{1,   1'b1, 1'b1, 9'h1FF, 9'h000, 2'b11, 2'b00, 0, 0};
    tbl[3] = '{600, 1'b0, 1'b1, 9'h1FF, 9'h000, 2'b10, 2'b01, 0, 0};
    tbl[4] = '{1,   1'b1, 1'b1, 9'h000, 9'h1FF, 2'b11, 2'b00, 0, 0};
    tbl[5] = '{300, 1'b0, 1'b1, 9'h000, 9'h1FF, 2'b01, 2'b10, 0, 0};

    bus_b.enable     = 1'b1;
    bus_b.difficulty = {9'h1FF, 9'h1FF};

    for (int v = 0; v < 6; v++) begin
      reset            = tbl[v].rst;
      bus_a.enable     = tbl[v].en;
      bus_a.difficulty = {tbl[v].d1, tbl[v].d0};
      for (int c = 0; c < tbl[v].cycles; c++) begin
        tick();
        for (int p = 0; p < 2; p++) begin
          if (tbl[v].quiet[p]) begin
            chk("quiet_press", act_press(p), 0);
            chk("quiet_cnt", act_cnt(p), (p == 0) ? tbl[v].exp_cnt0 : tbl[v].exp_cnt1);
          end
        end
      end
      if (v == 0) begin
        chk("seed_lfsr0", act_lfsr(0), 'h2A4);
        chk("seed_lfsr1", act_lfsr(1), 'h2A7);
      end
      for (int p = 0; p < 2; p++) begin
        if (tbl[v].active[p]) begin
          chk("cnt_vs_pulses", act_cnt(p), pulses[p]);
          chk_ge("some_presses", pulses[p], 1);
        end
      end
    end

    // Reset while player 1 is cooling down.
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      tick();
      if (act_press(1) != 0) found = 1;
    end
    chk("wait_press1", found, 1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_cool_press", int'(bus_a.press), 0);
    chk("rst_cool_cnt0", act_cnt(0), 0);
    chk("rst_cool_cnt1", act_cnt(1), 0);
    chk("rst_cool_lfsr0", act_lfsr(0), 'h2A4);
    chk("rst_cool_lfsr1", act_lfsr(1), 'h2A7);

    // Drop enable right after the edge that evaluates a hit.
    bus_a.enable     = 1'b1;
    bus_a.difficulty = {9'h000, 9'h1FF};
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      if (m_st[0] == 0 && (m_lfsr[0] & 'h1FF) < 'h1FF) found = 1;
      else tick();
    end
    chk("hit_found", found, 1);
    tick();
    bus_a.enable = 1'b0;
    chk("press_after_drop", act_press(0), 1);
    saved = act_cnt(0);
    for (int n = 0; n < 30; n++) begin
      tick();
      chk("no_press_en_low", act_press(0), 0);
    end
    chk("cnt_hold_en_low", act_cnt(0), saved);

    // Saturation of the COOLDOWN=0, 4-bit counter build.
    reset = 1'b1;
    tick();
    reset            = 1'b0;
    bus_a.enable     = 1'b1;
    bus_a.difficulty = {9'h1FF, 9'h1FF};
    for (int n = 0; n < 200; n++) tick();
    chk("sat_cnt_b0", act_cnt(2), 15);
    chk("sat_cnt_b1", act_cnt(3), 15);
    chk_ge("b_pulses", pulses[2], 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cyber_player_multi.md
Name: cyber_player_multi

Overview:
- Parametrised successor to the single computer-opponent block for the tug-of-war game.
- Generates pseudo-random button presses for N_PLAYERS independent computer players. Each player has its own difficulty input and its own LFSR.
- Each press is a clean one-cycle pulse followed by an enforced cooldown. A per-player saturating press counter supports scoring and debug.
- Outputs feed the same press inputs a human button path drives in the game datapath.

Parameters:
- N_PLAYERS, 2, number of independent computer players (1..8).
- LFSR_W, 10, LFSR width in bits (>= DIFF_W).
- TAPS, 10'b1001000000, LFSR feedback tap mask, width LFSR_W (default x^10+x^7+1).
- SEED, 10'h2A5, base seed, width LFSR_W.
- DIFF_W, 9, difficulty width per player.
- COOLDOWN, 4, idle cycles forced after each press (0 allowed).
- CNT_W, 8, width of each press counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  global game-running qualifier; new presses start only while high.
- difficulty  in  N_PLAYERS*DIFF_W  per-player threshold; player i uses bits [i*DIFF_W +: DIFF_W]. Larger value means presses are more frequent.
- press  out  N_PLAYERS  per-player one-cycle press pulse, registered.
- press_cnt  out  N_PLAYERS*CNT_W  per-player saturating count of issued presses.

Behaviour:
- Reset is synchronous and active-high; it is applied on any rising edge while reset=1, including mid-press or mid-cooldown. Reset values:
  - lfsr_i = SEED ^ (i+1); if that value is zero, load 1 instead.
  - state_i = IDLE.
  - press = 0.
  - press_cnt = 0.
  - cooldown counter = 0.
- LFSR, per player:
  - Advances every cycle when not in reset, independent of enable and state.
  - next = {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)}.
  - If lfsr is ever all-zero, it is reloaded with 1 on the next edge (lockup guard).
- Draw: draw_i = lfsr_i[DIFF_W-1:0], compared unsigned against diff_i.
- Hit condition: hit_i = enable && state_i==IDLE && (draw_i < diff_i).
  - diff_i = 0 never hits.
  - diff_i = all-ones hits on every draw except draw = all-ones.
- Per-player FSM, states IDLE, FIRE, COOL:
  - IDLE: if hit_i, go to FIRE; otherwise stay in IDLE.
  - FIRE: press_i = 1 for exactly this one cycle. press_cnt_i increments, saturating at 2^CNT_W-1. Next state is COOL with counter = COOLDOWN; if COOLDOWN=0, next state is IDLE.
  - COOL: counter decrements each cycle; go to IDLE on the edge where counter==1.
- press is decoded from state==FIRE through a register. Latency: hit evaluated in cycle t gives press high in cycle t+1.
- Minimum spacing between press rising edges is COOLDOWN+2 cycles. press is never high on two consecutive cycles.
- enable is low mid-sequence: a FIRE or COOL already in progress runs to completion. No new FIRE starts while enable is low. press_cnt holds its value.
- Players are fully independent. Simultaneous hits on several players all produce presses in the same cycle.
- Difficulty changes take effect at the next IDLE evaluation. There is no latching.

Test Plan:
- Reset held 3 cycles, then released with enable=0 and difficulty all-ones for 50 cycles -> press=0 and press_cnt=0 throughout; lfsr_0 after reset equals SEED^1 = 10'h2A4.
- Reset, enable=1, player 0 difficulty=9'h1FF, COOLDOWN=4, run 600 cycles:
  - every press pulse lasts exactly 1 cycle;
  - gaps between rising edges are always >= 6;
  - press_cnt_0 equals the number of pulses counted by the bench.
- Player 0 difficulty=0, player 1 difficulty=9'h1FF, enable=1, 300 cycles -> press[0] never asserts and press_cnt_0=0; press[1] count is > 0 and matches press_cnt_1.
- Reset asserted for one cycle while player 1 is in COOL (two cycles after a press) -> the next cycle shows press=0 and press_cnt=0, and the LFSRs are reloaded to their seed values.
- enable dropped in the cycle a hit is evaluated -> that press still appears the next cycle and COOL completes; no further presses until enable returns high.
- COOLDOWN=0 build with CNT_W=4 and difficulty all-ones, 200 cycles -> presses spaced >= 2 cycles apart; press_cnt saturates at 15 and does not wrap.
